// File: rtl/pipe_skid_pkg.sv
// pipe_skid_pkg: shared types and constants for the pipe_skid_reg stage.
//   pipe_state_t - occupancy state of the stage (empty / main valid / main + skid valid)
//   STALL_CNT_W  - width of the optional stall counter (PIPE_SKID_STALL_CNT_EN)
package pipe_skid_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } pipe_state_t;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_reg_cell.sv
// pipe_reg_cell: WIDTH-bit enable register with asynchronous active-low reset.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - asynchronous active-low reset, loads RESET_VAL
//   en_i   - load enable
//   d_i    - next value
//   q_o    - registered value
module pipe_reg_cell #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline-stage register with valid/ready handshake and a one-entry skid
// buffer. Sustains one transfer per cycle while in_ready comes straight from a flop, so there
// is no combinational path from out_ready to in_ready. flush squashes everything held.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to add a 16-bit saturating stall counter.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   flush      - synchronous squash of all held entries
//   in_valid   - upstream has data
//   in_ready   - stage can accept (registered)
//   in_data    - upstream payload
//   out_valid  - main entry holds valid data (registered)
//   out_ready  - downstream accepts
//   out_data   - main entry payload
//   stall_cnt  - cycles with out_valid & !out_ready, saturating (only with the macro)
module pipe_skid_reg
    import pipe_skid_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [WIDTH-1:0]       out_data
);

    pipe_state_t      state_q, state_d;
    logic             out_valid_q, in_ready_q;
    logic             in_fire, out_fire;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_fire && in_fire) begin
                    main_en = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat behind the main entry.
                    skid_en = 1'b1;
                    state_d = ST_SKID;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Squash overrides everything; data registers may still load, they are don't-care.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Handshake outputs are flopped from the next state so they never see out_ready
    // combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_SKID);
        end
    end

    pipe_reg_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_reg_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (skid_en),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Only reset clears the counter; flush leaves it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg. A table of per-cycle vectors carries
// hand-derived out_valid/in_ready expectations; a queue scoreboard holds accepted payloads and
// is compared against out_data. Inputs are driven and outputs sampled on the falling edge.
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_SKID_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_data  (out_data)
    );

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         exp_ov;
        logic         exp_ir;
    } vec_t;

    vec_t         vecs[24];
    logic [W-1:0] sb[$];
    int           checks = 0;
    int           errors = 0;
    int           delivered = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare live outputs against the scoreboard occupancy and head entry.
    task automatic check_sb();
        chk("sb_out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
        chk("sb_in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
        if (sb.size() > 0) chk("sb_out_data", out_data, sb[0]);
    endtask

    // Called just after a falling edge; drives one cycle and returns at the next falling edge.
    task automatic apply(input logic fl, input logic iv, input logic [W-1:0] d,
                         input logic ordy);
        logic in_ok;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        in_ok = iv && (sb.size() < 2);
        if (out_valid && ordy) delivered++;
        if (sb.size() > 0 && ordy) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (in_ok) sb.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            fl    iv    data          ordy  ov    ir
        vecs[0]  = '{1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'hA000_0003, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'hA000_0003, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'hB000_0002, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'hB000_0003, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 32'hC000_0001, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 32'hC000_0002, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 32'hD000_0001, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'h0);
`ifdef PIPE_SKID_STALL_CNT_EN
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

        for (int i = 0; i < 24; i++) begin
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ir});
            check_sb();
            apply(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
        end
        check_sb();
        // 3 streamed + 3 skid + 1 delivered during flush + 1 after hold; flushed B values never.
        chk("delivered_count", delivered, 32'd8);

        // Asynchronous reset between edges while FULL.
        apply(1'b0, 1'b1, 32'hF000_0001, 1'b0);
        check_sb();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_out_data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        check_sb();

`ifdef PIPE_SKID_STALL_CNT_EN
        apply(1'b0, 1'b1, 32'hE000_0001, 1'b0);
        repeat (5) apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
        check_sb();
        repeat (32'hFFFE - 5) apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_cnt_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
        repeat (3) apply(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        apply(1'b1, 1'b0, 32'h0, 1'b1);
        check_sb();
        chk("stall_cnt_flush_kept", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
